shift_rows_pipe: RTL and testbench



---
 rtl/shift_rows_pipe.sv | 146 ++++++++++++++
 tb/tb_shift_rows_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : shift_rows_pipe
//  Purpose  : Registered ShiftRows / InvShiftRows stage for a Rijndael
//             datapath with NB = 4, 6 or 8 state columns. The byte permutation
//             is combinational on the input side. Results land in a 2-entry
//             FIFO: a head entry that drives the outputs, and a skid entry.
//             in_ready depends only on the FIFO occupancy, so there is no
//             combinational path from out_ready back to in_ready.
//  Ports    : clk, rst_n (async, active-low), flush (sync clear)
//             in_valid / in_ready / in_data[32*NB] / in_inv / in_tag[TAG_W]
//             out_valid / out_ready / out_data[32*NB] / out_tag[TAG_W]
//             State byte (r,c) sits at bits [8*(4c+r) +: 8].
//  Options  : SHIFT_ROWS_PIPE_INV_EN - when defined, in_inv selects the
//             inverse transform. When undefined, in_inv is ignored and only
//             the forward permutation is built.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32*NB-1:0]   in_data,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int c_DW = 32 * NB;

    // Occupancy-encoded state: the state value is the number of stored blocks.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Byte permutation. Row r rotates by s_r columns. For Nb=8 the rows
    // 2 and 3 use offsets 3 and 4 instead of 2 and 3.
    // ------------------------------------------------------------------
    logic [c_DW-1:0] w_fwd;
    logic [c_DW-1:0] w_xf;
`ifdef SHIFT_ROWS_PIPE_INV_EN
    logic [c_DW-1:0] w_inv;
`endif

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int c_SH = (NB == 8 && r >= 2) ? r + 1 : r;
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int c_SRC = (c + c_SH) % NB;
            // Forward gathers from column c+s; inverse scatters column c
            // to column c+s, which is the same wiring read backwards.
            assign w_fwd[8*(4*c+r) +: 8] = in_data[8*(4*c_SRC+r) +: 8];
`ifdef SHIFT_ROWS_PIPE_INV_EN
            assign w_inv[8*(4*c_SRC+r) +: 8] = in_data[8*(4*c+r) +: 8];
`endif
        end
    end

`ifdef SHIFT_ROWS_PIPE_INV_EN
    assign w_xf = in_inv ? w_inv : w_fwd;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_xf         = w_fwd;
`endif

    // ------------------------------------------------------------------
    // 2-entry FIFO (head + skid)
    // ------------------------------------------------------------------
    logic [1:0]       r_count;
    logic [c_DW-1:0]  r_head_data;
    logic [c_DW-1:0]  r_skid_data;
    logic [TAG_W-1:0] r_head_tag;
    logic [TAG_W-1:0] r_skid_tag;
    logic             w_accept;
    logic             w_pop;

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != c_EMPTY);
    assign out_data  = r_head_data;
    assign out_tag   = r_head_tag;
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= c_EMPTY;
            r_head_data <= '0;
            r_head_tag  <= '0;
            r_skid_data <= '0;
            r_skid_tag  <= '0;
        end else if (flush) begin
            // Flush overrides any same-cycle accept or pop; stale data
            // registers are harmless because out_valid goes low.
            r_count <= c_EMPTY;
        end else begin
            case (r_count)
                c_EMPTY: begin
                    if (w_accept) begin
                        r_head_data <= w_xf;
                        r_head_tag  <= in_tag;
                        r_count     <= c_ONE;
                    end
                end
                c_ONE: begin
                    if (w_accept && w_pop) begin
                        // Head leaves, new block takes its place.
                        r_head_data <= w_xf;
                        r_head_tag  <= in_tag;
                    end else if (w_accept) begin
                        r_skid_data <= w_xf;
                        r_skid_tag  <= in_tag;
                        r_count     <= c_FULL;
                    end else if (w_pop) begin
                        r_count <= c_EMPTY;
                    end
                end
                c_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_head_data <= r_skid_data;
                        r_head_tag  <= r_skid_tag;
                        r_count     <= c_ONE;
                    end
                end
                default: r_count <= c_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_rows_pipe
//  Purpose  : Self-checking bench for shift_rows_pipe. One NB=4 and one NB=8
//             instance; each has a scoreboard queue fed on accept and drained
//             on pop, plus directed checks for the known vectors,
//             backpressure, flush and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rows_pipe;

    typedef struct packed {
        logic [255:0] data;
        logic [3:0]   tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;

    logic         in_valid4 = 1'b0, in_ready4, in_inv4 = 1'b0;
    logic [127:0] in_data4 = '0, out_data4;
    logic [3:0]   in_tag4 = '0, out_tag4;
    logic         out_valid4, out_ready4 = 1'b1;

    logic         in_valid8 = 1'b0, in_ready8, in_inv8 = 1'b0;
    logic [255:0] in_data8 = '0, out_data8;
    logic [3:0]   in_tag8 = '0, out_tag8;
    logic         out_valid8, out_ready8 = 1'b1;

    int total = 0;
    int bad   = 0;

    exp_t q4[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_inv(in_inv4), .in_tag(in_tag4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_tag(out_tag4)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_inv(in_inv8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .out_tag(out_tag8)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference permutation: gather form for forward, scatter form for inverse.
    function automatic logic [255:0] model(input logic [255:0] d, input int nb, input logic inv);
        logic [255:0] o;
        int s;
        int k;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            s = (nb == 8 && r > 1) ? r + 1 : r;
            for (int c = 0; c < nb; c++) begin
                k = (c + s) % nb;
                if (inv) o[8*(4*k+r) +: 8] = d[8*(4*c+r) +: 8];
                else     o[8*(4*c+r) +: 8] = d[8*(4*k+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic eff_inv(input logic inv);
`ifdef SHIFT_ROWS_PIPE_INV_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards sample on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst_n || flush) begin
            q4.delete();
        end else begin
            if (out_valid4 && out_ready4) begin
                chk("q4_avail", 256'(q4.size() != 0), 256'(1));
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("data4", 256'(out_data4), e.data);
                    chk("tag4", 256'(out_tag4), 256'(e.tag));
                end
            end
            if (in_valid4 && in_ready4) begin
                e.data = model(256'(in_data4), 4, eff_inv(in_inv4));
                e.tag  = in_tag4;
                q4.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst_n || flush) begin
            q8.delete();
        end else begin
            if (out_valid8 && out_ready8) begin
                chk("q8_avail", 256'(q8.size() != 0), 256'(1));
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("data8", out_data8, e.data);
                    chk("tag8", 256'(out_tag8), 256'(e.tag));
                end
            end
            if (in_valid8 && in_ready8) begin
                e.data = model(in_data8, 8, eff_inv(in_inv8));
                e.tag  = in_tag8;
                q8.push_back(e);
            end
        end
    end

    initial begin : stim
        logic [127:0] v_in;
        logic [127:0] v_out;
        logic [255:0] v8;
        logic [255:0] exp_inv;
        int acc4;
        int cyc;

        v_in  = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
        v_out = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

        // Reset state
        #1;
        chk("rst_out_valid", 256'(out_valid4), 256'(0));
        chk("rst_in_ready", 256'(in_ready4), 256'(1));
        chk("rst_out_data", 256'(out_data4), 256'(0));
        chk("rst_out_tag", 256'(out_tag4), 256'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // NB=4 forward known vector, one-cycle latency
        in_valid4 = 1'b1; in_data4 = v_in; in_tag4 = 4'd5; in_inv4 = 1'b0; out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        chk("fwd4_valid", 256'(out_valid4), 256'(1));
        chk("fwd4_data", 256'(out_data4), 256'(v_out));
        chk("fwd4_tag", 256'(out_tag4), 256'(5));
        step();

        // NB=4 inverse on the forward result
`ifdef SHIFT_ROWS_PIPE_INV_EN
        exp_inv = 256'(v_in);
`else
        exp_inv = model(256'(v_out), 4, 1'b0);
`endif
        in_valid4 = 1'b1; in_data4 = v_out; in_tag4 = 4'd6; in_inv4 = 1'b1;
        step();
        in_valid4 = 1'b0; in_inv4 = 1'b0;
        chk("inv4_data", 256'(out_data4), exp_inv);
        step();

        // NB=8 forward, b_i = i
        for (int i = 0; i < 32; i++) v8[8*i +: 8] = 8'(i);
        in_valid8 = 1'b1; in_data8 = v8; in_tag8 = 4'd7; in_inv8 = 1'b0; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        chk("fwd8_col0", 256'(out_data8[31:0]), 256'(32'h130e0500));
        chk("fwd8_data", out_data8, model(v8, 8, 1'b0));
        chk("fwd8_tag", 256'(out_tag8), 256'(7));
        step();

        // Throughput: one block per cycle with out_ready held high
        for (int i = 0; i < 6; i++) begin
            in_valid4 = 1'b1; in_data4 = 128'(rnd256()); in_tag4 = 4'(i);
            chk("tput_ready", 256'(in_ready4), 256'(1));
            if (i > 0) chk("tput_valid", 256'(out_valid4), 256'(1));
            step();
        end
        in_valid4 = 1'b0;
        step();
        step();

        // Backpressure: tags 1,2,3 with out_ready low
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; in_data4 = 128'(rnd256()); in_tag4 = 4'd1;
        step();
        in_data4 = 128'(rnd256()); in_tag4 = 4'd2;
        step();
        chk("bp_ready_full", 256'(in_ready4), 256'(0));
        in_data4 = 128'(rnd256()); in_tag4 = 4'd3;
        step();
        chk("bp_ready_hold", 256'(in_ready4), 256'(0));
        chk("bp_head_tag", 256'(out_tag4), 256'(1));
        out_ready4 = 1'b1;
        step();
        chk("bp_valid2", 256'(out_valid4), 256'(1));
        chk("bp_tag2", 256'(out_tag4), 256'(2));
        step();
        in_valid4 = 1'b0;
        chk("bp_valid3", 256'(out_valid4), 256'(1));
        chk("bp_tag3", 256'(out_tag4), 256'(3));
        step();
        chk("bp_drained", 256'(out_valid4), 256'(0));

        // Flush from FULL with in_valid high
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; in_tag4 = 4'd8;
        step();
        in_tag4 = 4'd9;
        step();
        chk("fl_full", 256'(in_ready4), 256'(0));
        flush = 1'b1; out_ready4 = 1'b1;
        step();
        flush = 1'b0; in_valid4 = 1'b0;
        chk("fl_full_valid", 256'(out_valid4), 256'(0));
        chk("fl_full_ready", 256'(in_ready4), 256'(1));
        // Flush from ONE while an accept and pop would also happen
        in_valid4 = 1'b1; in_tag4 = 4'd10;
        step();
        flush = 1'b1; in_tag4 = 4'd11;
        step();
        flush = 1'b0; in_valid4 = 1'b0;
        chk("fl_one_valid", 256'(out_valid4), 256'(0));
        step();

        // Asynchronous reset mid-stream
        out_ready4 = 1'b0;
        in_valid4 = 1'b1; in_data4 = 128'(rnd256()); in_tag4 = 4'd12;
        in_valid8 = 1'b1; in_data8 = rnd256(); in_tag8 = 4'd13;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid4", 256'(out_valid4), 256'(0));
        chk("ar_ready4", 256'(in_ready4), 256'(1));
        chk("ar_valid8", 256'(out_valid8), 256'(0));
        in_valid4 = 1'b0; in_valid8 = 1'b0; out_ready4 = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ar_after", 256'(out_valid4), 256'(0));

        // Random valid/ready traffic on both instances
        acc4 = 0;
        cyc  = 0;
        while (acc4 < 10000 && cyc < 60000) begin
            in_valid4  = ($urandom_range(0, 3) != 0);
            in_data4   = 128'(rnd256());
            in_inv4    = 1'($urandom);
            in_tag4    = 4'($urandom);
            out_ready4 = ($urandom_range(0, 3) != 0);
            in_valid8  = ($urandom_range(0, 2) != 0);
            in_data8   = rnd256();
            in_inv8    = 1'($urandom);
            in_tag8    = 4'($urandom);
            out_ready8 = ($urandom_range(0, 2) != 0);
            if (in_valid4 && in_ready4) acc4++;
            step();
            cyc++;
        end
        chk("rand_blocks", 256'(acc4 >= 10000), 256'(1));

        // Drain and confirm nothing is left over
        in_valid4 = 1'b0; in_valid8 = 1'b0; out_ready4 = 1'b1; out_ready8 = 1'b1;
        for (int i = 0; i < 10 && (q4.size() != 0 || q8.size() != 0); i++) step();
        step();
        chk("drain_q4", 256'(q4.size()), 256'(0));
        chk("drain_q8", 256'(q8.size()), 256'(0));
        chk("drain_valid4", 256'(out_valid4), 256'(0));
        chk("drain_valid8", 256'(out_valid8), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
